// File: rtl/riscv_pkg.sv
// Shared decode definitions for the RV32I filter core: opcodes, ALU
// encodings, decode-stage state and the execute-bound bundle.
package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_FUNC = 2'b01;
    localparam logic [1:0] ALU_PASS = 2'b10;

    typedef enum logic [1:0] {
        EMPTY,
        FULL,
        BUBBLE
    } dec_state_t;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_t;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       op2_sel;
        logic       op1_pc;
        logic       reg_we;
        logic       mem_re;
        logic       mem_we;
        logic       branch;
        logic       jump;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  func3;
        logic        instr30;
        ctrl_t       ctrl;
    } id_ex_t;

    function automatic ctrl_t decode_ctrl(input logic [6:0] opc);
        ctrl_t c;
        c = '0;
        case (opc)
            OPC_OP: begin
                c.alu_op = ALU_FUNC;
                c.reg_we = 1'b1;
            end
            OPC_OP_IMM: begin
                c.alu_op  = ALU_FUNC;
                c.op2_sel = 1'b1;
                c.reg_we  = 1'b1;
            end
            OPC_LOAD: begin
                c.op2_sel = 1'b1;
                c.reg_we  = 1'b1;
                c.mem_re  = 1'b1;
            end
            OPC_STORE: begin
                c.op2_sel = 1'b1;
                c.mem_we  = 1'b1;
            end
            OPC_BRANCH: begin
                c.op2_sel = 1'b1;
                c.branch  = 1'b1;
            end
            OPC_JALR: begin
                c.op2_sel = 1'b1;
                c.jump    = 1'b1;
                c.reg_we  = 1'b1;
            end
            OPC_AUIPC: begin
                c.op1_pc  = 1'b1;
                c.op2_sel = 1'b1;
                c.reg_we  = 1'b1;
            end
            OPC_JAL: begin
                c.op1_pc  = 1'b1;
                c.op2_sel = 1'b1;
                c.jump    = 1'b1;
                c.reg_we  = 1'b1;
            end
            OPC_LUI: begin
                c.alu_op  = ALU_PASS;
                c.op2_sel = 1'b1;
                c.reg_we  = 1'b1;
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    function automatic imm_fmt_t imm_fmt_of(input logic [6:0] opc);
        imm_fmt_t f;
        case (opc)
            OPC_OP_IMM,
            OPC_LOAD,
            OPC_JALR:   f = IMM_I;
            OPC_STORE:  f = IMM_S;
            OPC_BRANCH: f = IMM_B;
            OPC_LUI,
            OPC_AUIPC:  f = IMM_U;
            OPC_JAL:    f = IMM_J;
            default:    f = IMM_NONE;
        endcase
        return f;
    endfunction

    // {rs2 used, rs1 used}: only real source fields may raise a hazard
    function automatic logic [1:0] src_use(input logic [6:0] opc);
        logic [1:0] u;
        case (opc)
            OPC_OP,
            OPC_STORE,
            OPC_BRANCH: u = 2'b11;
            OPC_OP_IMM,
            OPC_LOAD,
            OPC_JALR:   u = 2'b01;
            default:    u = 2'b00;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/riscv_imm_gen.sv
// Immediate generator: builds the sign-extended 32-bit immediate
// for the given instruction format.
module riscv_imm_gen
    import riscv_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_fmt_t    fmt,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        unique case (fmt)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25],
                          instr[11:7]};
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7],
                          instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'b0};
            IMM_J: imm = {{11{instr[31]}}, instr[31],
                          instr[19:12], instr[20],
                          instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/riscv_decode_stage.sv
// RV32I decode stage: registered control bundle for execute, with
// flush and optional load-use bubble (LOAD_USE_STALL_EN).
module riscv_decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [31:0]     imm,
    output logic [2:0]      func3,
    output logic            instr30,
    output logic [1:0]      alu_op,
    output logic            op2_sel,
    output logic            op1_pc,
    output logic            reg_we,
    output logic            mem_re,
    output logic            mem_we,
    output logic            branch,
    output logic            jump,
    output logic            illegal
);

    logic [6:0]      opc;
    ctrl_t           dec_ctrl;
    imm_fmt_t        dec_fmt;
    logic [31:0]     dec_imm;
    dec_state_t      state;
    dec_state_t      state_nxt;
    id_ex_t          bundle_q;
    logic [XLEN-1:0] pc_q;
    logic            hazard;
    logic            accept;
    logic            keep_full;
    logic            to_bubble;

    assign opc      = in_instr[6:0];
    assign dec_ctrl = decode_ctrl(opc);
    assign dec_fmt  = imm_fmt_of(opc);

    riscv_imm_gen u_imm_gen (
        .instr (in_instr[31:7]),
        .fmt   (dec_fmt),
        .imm   (dec_imm)
    );

`ifdef LOAD_USE_STALL_EN
    logic [1:0] use_src;
    logic       rs1_hit;
    logic       rs2_hit;

    assign use_src = src_use(opc);
    assign rs1_hit = use_src[0]
                  && (in_instr[19:15] == bundle_q.rd);
    assign rs2_hit = use_src[1]
                  && (in_instr[24:20] == bundle_q.rd);
    assign hazard  = out_valid
                  && bundle_q.ctrl.mem_re
                  && (bundle_q.rd != 5'd0)
                  && (rs1_hit || rs2_hit);
`else
    assign hazard = 1'b0;
`endif

    assign in_ready  = (!out_valid || out_ready)
                    && !hazard && !flush;
    assign accept    = in_valid && in_ready;
    assign keep_full = accept
                    || ((state == FULL) && !out_ready);
    assign to_bubble = (state == FULL) && out_ready && hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Flush wins over everything; hazard and accept never coincide
    always_comb begin
        state_nxt = EMPTY;
        unique case (1'b1)
            flush:                state_nxt = EMPTY;
            (!flush && keep_full): state_nxt = FULL;
            (!flush && to_bubble): state_nxt = BUBBLE;
            default:              state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        if (state == FULL) begin
            out_valid = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bundle_q <= '0;
            pc_q     <= '0;
        end else if (accept) begin
            bundle_q.rs1     <= in_instr[19:15];
            bundle_q.rs2     <= in_instr[24:20];
            bundle_q.rd      <= in_instr[11:7];
            bundle_q.imm     <= dec_imm;
            bundle_q.func3   <= in_instr[14:12];
            bundle_q.instr30 <= in_instr[30];
            bundle_q.ctrl    <= dec_ctrl;
            pc_q             <= in_pc;
        end
    end

    assign out_pc  = pc_q;
    assign rs1     = bundle_q.rs1;
    assign rs2     = bundle_q.rs2;
    assign rd      = bundle_q.rd;
    assign imm     = bundle_q.imm;
    assign func3   = bundle_q.func3;
    assign instr30 = bundle_q.instr30;
    assign alu_op  = bundle_q.ctrl.alu_op;
    assign op2_sel = bundle_q.ctrl.op2_sel;
    assign op1_pc  = bundle_q.ctrl.op1_pc;
    assign reg_we  = bundle_q.ctrl.reg_we;
    assign mem_re  = bundle_q.ctrl.mem_re;
    assign mem_we  = bundle_q.ctrl.mem_we;
    assign branch  = bundle_q.ctrl.branch;
    assign jump    = bundle_q.ctrl.jump;
    assign illegal = bundle_q.ctrl.illegal;

endmodule
